// File: rtl/mult_pkg.sv
// Shared definitions for the round-robin shift-add multiplier: state
// encoding, default operand width, iteration count and the arbitration pick.
package mult_pkg;

  localparam int DEFAULT_W  = 16;
  localparam int ITER_COUNT = DEFAULT_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  // On a tie, pick whoever was not served last; a lone request always wins.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_served);
    logic pick;
    if (req0 && req1) begin
      pick = ~last_served;
    end else begin
      pick = req1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mult_seq_core.sv
// Iterative unsigned shift-add datapath: one partial product per step, W steps.
// o_product already includes the step being performed this cycle.
module mult_seq_core
  import mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_product,
  output logic           o_last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [2*W-1:0] r_a_sh;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;

  logic [2*W-1:0] w_addend;
  logic [2*W-1:0] w_acc_next;

  assign w_addend   = r_b[0] ? r_a_sh : '0;
  assign w_acc_next = r_acc + w_addend;

  assign o_product = w_acc_next;
  assign o_last    = (r_cnt == CW'(W - 1));

  // Multiplicand shifts left while the multiplier shifts right, so bit 0 of
  // r_b always selects the current partial product.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a_sh <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_a_sh <= {{W{1'b0}}, i_a};
      r_b    <= i_b;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (i_step) begin
      r_a_sh <= r_a_sh << 1;
      r_b    <= r_b >> 1;
      r_acc  <= w_acc_next;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for the sequential multiplier core.
// Owns the IDLE/RUN/FIN control, grant pulses and the held result registers.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         REQ0,
  input  logic         REQ1,
  input  logic [W-1:0] A0,
  input  logic [W-1:0] B0,
  input  logic [W-1:0] A1,
  input  logic [W-1:0] B1,
  output logic         ACK0,
  output logic         ACK1,
  input  logic         ABORT,
  output logic         BUSY,
  output logic         DONE,
  output logic         DONE_ID,
  output logic [W-1:0] HI,
  output logic [W-1:0] LO
);

  logic [1:0]   r_state;
  logic         r_id;
  logic         r_last_served;
  logic         r_ack0;
  logic         r_ack1;
  logic         r_done_id;
  logic [W-1:0] r_hi;
  logic [W-1:0] r_lo;

  logic           w_any_req;
  logic           w_gnt_id;
  logic           w_load;
  logic           w_step;
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic [2*W-1:0] w_product;
  logic           w_last;

  assign w_any_req = REQ0 | REQ1;
  assign w_gnt_id  = rr_pick(REQ0, REQ1, r_last_served);
  assign w_load    = (r_state == IDLE) && w_any_req;
  assign w_step    = (r_state == RUN) && !ABORT;
  assign w_a       = w_gnt_id ? A1 : A0;
  assign w_b       = w_gnt_id ? B1 : B0;

  mult_seq_core #(
    .W(W)
  ) u_core (
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_product(w_product),
    .o_last   (w_last)
  );

  // An abort in RUN counts as having served that requester, so the other
  // side gets the next tie.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state       <= IDLE;
      r_id          <= 1'b0;
      r_last_served <= 1'b1;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_done_id     <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state <= RUN;
            r_id    <= w_gnt_id;
            r_ack0  <= ~w_gnt_id;
            r_ack1  <= w_gnt_id;
          end
        end
        RUN: begin
          if (ABORT) begin
            r_state       <= IDLE;
            r_last_served <= r_id;
          end else if (w_last) begin
            r_state   <= FIN;
            r_hi      <= w_product[2*W-1:W];
            r_lo      <= w_product[W-1:0];
            r_done_id <= r_id;
          end
        end
        FIN: begin
          r_state       <= IDLE;
          r_last_served <= r_id;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ACK0    = r_ack0;
  assign ACK1    = r_ack1;
  assign BUSY    = (r_state != IDLE);
  assign DONE    = (r_state == FIN);
  assign DONE_ID = r_done_id;
  assign HI      = r_hi;
  assign LO      = r_lo;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter (W=16): latency, round-robin
// order, abort, zero operands and mid-operation reset.
module tb_mult_arbiter;

  localparam int W = 16;

  logic         CLK;
  logic         RST_N;
  logic         REQ0, REQ1;
  logic [W-1:0] A0, B0, A1, B1;
  logic         ACK0, ACK1;
  logic         ABORT;
  logic         BUSY, DONE, DONE_ID;
  logic [W-1:0] HI, LO;

  int compareCount  = 0;
  int mismatchCount = 0;

  mult_arbiter #(.W(W)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .REQ0   (REQ0),
    .REQ1   (REQ1),
    .A0     (A0),
    .B0     (B0),
    .A1     (A1),
    .B1     (B1),
    .ACK0   (ACK0),
    .ACK1   (ACK1),
    .ABORT  (ABORT),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .DONE_ID(DONE_ID),
    .HI     (HI),
    .LO     (LO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req0, input logic req1,
                               input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic [W-1:0] a1, input logic [W-1:0] b1);
    REQ0 = req0;
    REQ1 = req1;
    A0   = a0;
    B0   = b0;
    A1   = a1;
    B1   = b1;
  endtask

  // Called in the ACK cycle (index 0); follows the operation back to IDLE.
  task automatic runOp(output int doneAt, output int busyLen,
                       output logic doneId, output logic [2*W-1:0] prod);
    doneAt  = -1;
    busyLen = 0;
    doneId  = 1'b0;
    prod    = '0;
    for (int i = 0; i < 40; i++) begin
      if (!BUSY) break;
      busyLen++;
      if (DONE) begin
        doneAt = i;
        doneId = DONE_ID;
        prod   = {HI, LO};
      end
      tick();
    end
  endtask

  task automatic checkOp(input string tag, input logic expId,
                         input logic [2*W-1:0] expProd);
    int doneAt, busyLen;
    logic doneId;
    logic [2*W-1:0] prod;
    runOp(doneAt, busyLen, doneId, prod);
    checkOutput({tag, "_done_at"}, 64'(doneAt), 64'd16);
    checkOutput({tag, "_busy_len"}, 64'(busyLen), 64'd17);
    checkOutput({tag, "_done_id"}, 64'(doneId), 64'(expId));
    checkOutput({tag, "_product"}, 64'(prod), 64'(expProd));
  endtask

  int ackT[4];
  logic ackWho[4];
  int doneT[4];
  logic doneWho[4];
  logic [2*W-1:0] doneProd[4];
  int nAck, nDone, doneSeen;

  initial begin
    RST_N = 1'b0;
    ABORT = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    tick();
    tick();
    checkOutput("rst_busy", 64'(BUSY), 64'd0);
    checkOutput("rst_done", 64'(DONE), 64'd0);
    checkOutput("rst_acks", 64'({ACK0, ACK1}), 64'd0);
    checkOutput("rst_hilo", 64'({HI, LO}), 64'd0);
    checkOutput("rst_done_id", 64'(DONE_ID), 64'd0);
    RST_N = 1'b1;
    tick();

    // 3*5 from requester 0
    applyStimulus(1'b1, 1'b0, 16'd3, 16'd5, '0, '0);
    tick();
    checkOutput("t1_ack0", 64'(ACK0), 64'd1);
    checkOutput("t1_ack1", 64'(ACK1), 64'd0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    checkOp("t1", 1'b0, 32'h0000_000F);

    // Largest operands from requester 1
    applyStimulus(1'b0, 1'b1, '0, '0, 16'hFFFF, 16'hFFFF);
    tick();
    checkOutput("t2_ack1", 64'(ACK1), 64'd1);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    checkOp("t2", 1'b1, 32'hFFFE_0001);

    // Held tie after reset grants 0, 1, 0 eighteen cycles apart
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'd2, 16'd4, 16'd5, 16'd6);
    nAck  = 0;
    nDone = 0;
    for (int t = 1; t <= 60; t++) begin
      tick();
      if ((ACK0 || ACK1) && nAck < 4) begin
        ackT[nAck]   = t;
        ackWho[nAck] = ACK1;
        nAck++;
        if (nAck == 3) applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
      end
      if (DONE && nDone < 4) begin
        doneT[nDone]    = t;
        doneWho[nDone]  = DONE_ID;
        doneProd[nDone] = {HI, LO};
        nDone++;
      end
    end
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    checkOutput("t3_ack_count", 64'(nAck), 64'd3);
    checkOutput("t3_done_count", 64'(nDone), 64'd3);
    if (nAck >= 3 && nDone >= 3) begin
      checkOutput("t3_ack_t0", 64'(ackT[0]), 64'd1);
      checkOutput("t3_ack_gap1", 64'(ackT[1] - ackT[0]), 64'd18);
      checkOutput("t3_ack_gap2", 64'(ackT[2] - ackT[1]), 64'd18);
      checkOutput("t3_order", 64'({ackWho[0], ackWho[1], ackWho[2]}), 64'b010);
      checkOutput("t3_done_ids", 64'({doneWho[0], doneWho[1], doneWho[2]}), 64'b010);
      checkOutput("t3_done_t0", 64'(doneT[0]), 64'd17);
      checkOutput("t3_prod0", 64'(doneProd[0]), 64'd8);
      checkOutput("t3_prod1", 64'(doneProd[1]), 64'd30);
      checkOutput("t3_prod2", 64'(doneProd[2]), 64'd8);
    end
    while (BUSY && nAck < 100) begin
      tick();
      nAck++;
    end

    // Zero multiplicand still runs all steps
    applyStimulus(1'b1, 1'b0, 16'd0, 16'h1234, '0, '0);
    tick();
    checkOutput("t6_ack0", 64'(ACK0), 64'd1);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    checkOp("t6", 1'b0, 32'h0);

    // 2*3 completes, then 7*9 is aborted at step 5
    applyStimulus(1'b1, 1'b0, 16'd2, 16'd3, '0, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    checkOp("t4a", 1'b0, 32'h6);
    applyStimulus(1'b1, 1'b0, 16'd7, 16'd9, '0, '0);
    tick();
    checkOutput("t4_ack0", 64'(ACK0), 64'd1);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    repeat (5) tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    checkOutput("t4_busy_after_abort", 64'(BUSY), 64'd0);
    checkOutput("t4_hilo_after_abort", 64'({HI, LO}), 64'h0000_0006);
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      if (DONE) doneSeen++;
      tick();
    end
    checkOutput("t4_no_done", 64'(doneSeen), 64'd0);

    // ABORT together with a request in IDLE: the request wins
    applyStimulus(1'b0, 1'b1, '0, '0, 16'h0100, 16'h0100);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    checkOutput("t4b_ack1", 64'(ACK1), 64'd1);
    checkOutput("t4b_busy", 64'(BUSY), 64'd1);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    checkOp("t4b", 1'b1, 32'h0001_0000);

    applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0010, '0, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    checkOp("t5a", 1'b0, 32'h0001_2340);

    // Reset mid-run; requester 0 was served last, yet the tie goes to 0
    applyStimulus(1'b0, 1'b1, '0, '0, 16'd5, 16'd5);
    tick();
    checkOutput("t5_ack1", 64'(ACK1), 64'd1);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    repeat (7) tick();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    checkOutput("t5_rst_busy", 64'(BUSY), 64'd0);
    checkOutput("t5_rst_done", 64'(DONE), 64'd0);
    checkOutput("t5_rst_acks", 64'({ACK0, ACK1}), 64'd0);
    checkOutput("t5_rst_hilo", 64'({HI, LO}), 64'd0);
    checkOutput("t5_rst_done_id", 64'(DONE_ID), 64'd0);
    applyStimulus(1'b1, 1'b1, 16'h0011, 16'h0011, 16'd3, 16'd3);
    tick();
    checkOutput("t5_tie_ack0", 64'(ACK0), 64'd1);
    checkOutput("t5_tie_ack1", 64'(ACK1), 64'd0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    checkOp("t5b", 1'b0, 32'h0000_0121);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
